mem_port_arbiter: RTL

- Sits directly downstream of the LC-3b pipeline core's two memory ports.
- Merges port A (instruction fetch, read-only) and port B (data, read/write with byte mask) onto one physical memory port with a resp handshake.
- Serves one transaction at a time.
- Data accesses take priority by default; a streak limit prevents instruction-fetch starvation.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: merges the fetch port (A) and data port (B) onto one     |
// | memory port, B-priority with a streak limit guarding A.  Rev 1.0           |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int MAX_B_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_read,
  input  logic [15:0] a_address,
  output logic [15:0] a_rdata,
  output logic        a_resp,
  input  logic        b_read,
  input  logic        b_write,
  input  logic [1:0]  b_wmask,
  input  logic [15:0] b_address,
  input  logic [15:0] b_wdata,
  output logic [15:0] b_rdata,
  output logic        b_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_A = 3'd1,
    BUSY_B = 3'd2,
    RESP_A = 3'd3,
    RESP_B = 3'd4
  } state_t;

  localparam int             SW         = (MAX_B_STREAK < 1) ? 1 : $clog2(MAX_B_STREAK + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_B_STREAK);

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    wmask_q, wmask_d;
  logic [15:0]   a_rdata_q, a_rdata_d;
  logic [15:0]   b_rdata_q, b_rdata_d;

  logic          b_pend;
  logic          force_a;

  assign b_pend  = b_read | b_write;
  assign force_a = a_read && (MAX_B_STREAK != 0) && (streak_q == STREAK_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (!a_read) streak_d = '0;
        if (b_pend && !force_a) begin
          // A write wins when both read and write are requested.
          state_d = BUSY_B;
          wr_d    = b_write;
          addr_d  = b_address;
          wdata_d = b_write ? b_wdata : 16'h0000;
          wmask_d = b_write ? b_wmask : 2'b00;
          if (a_read && (streak_q != STREAK_MAX)) streak_d = streak_q + 1'b1;
        end else if (a_read) begin
          state_d  = BUSY_A;
          wr_d     = 1'b0;
          addr_d   = a_address;
          wdata_d  = 16'h0000;
          wmask_d  = 2'b00;
          streak_d = '0;
        end
      end
      BUSY_A: begin
        if (mem_resp) begin
          a_rdata_d = mem_rdata;
          state_d   = RESP_A;
        end
      end
      BUSY_B: begin
        if (mem_resp) begin
          if (!wr_q) b_rdata_d = mem_rdata;
          state_d = RESP_B;
        end
      end
      RESP_A:  state_d = IDLE;
      RESP_B:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Physical port is driven only from the latched transaction.
  assign mem_read    = (state_q == BUSY_A) || ((state_q == BUSY_B) && !wr_q);
  assign mem_write   = (state_q == BUSY_B) && wr_q;
  assign mem_wmask   = wmask_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign a_resp      = (state_q == RESP_A);
  assign b_resp      = (state_q == RESP_B);

endmodule
`default_nettype wire
